// File: rtl/latency_monitor.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : latency_monitor
// Description : GT loopback latency checker. Sends timestamped payload words
//               with a comma IDLE word every g_IDLE_PERIOD words. Checks RX
//               byte alignment and measures loopback latency in usrclk
//               cycles. Keeps last/min/max latency and saturating counts of
//               good samples and errors.
// Ports       : usrclk_i, rst_n_i     clock, async active-low reset
//               valid_i               link enable (low = TX IDLE, checker off)
//               clear_stats_i         clear min/max/counters
//               tx_data_o, tx_k_o     TX word and K flags
//               rx_data_i, rx_k_i     RX word and K flags
//               rx_aligned_i          GT comma alignment achieved
//               rx_bufstatus_i        GT elastic buffer status (bit2 = error)
//               rx_realign_o          comma realignment request
//               fail_o                low only while locked and passing
//               latency_*_o           last / min / max latency
//               sample_cnt_o          good payload words since clear
//               err_cnt_o             errors since clear
// Revision    : 1.0 - initial release
// ============================================================================
module latency_monitor #(
    parameter int                   g_BYTES        = 2,
    parameter logic [8*g_BYTES-1:0] g_IDLE         = 16'hbc95,
    parameter int                   g_IDLE_PERIOD  = 193,
    parameter int                   g_BLIND_PERIOD = 10,
    parameter int                   g_NUM_SAMPLES  = 1000,
    parameter int                   g_TS_W         = 16,
    parameter int                   g_CNT_W        = 32
) (
    input  logic                   usrclk_i,
    input  logic                   rst_n_i,
    input  logic                   valid_i,
    input  logic                   clear_stats_i,
    output logic [8*g_BYTES-1:0]   tx_data_o,
    output logic [g_BYTES-1:0]     tx_k_o,
    input  logic [8*g_BYTES-1:0]   rx_data_i,
    input  logic [g_BYTES-1:0]     rx_k_i,
    input  logic                   rx_aligned_i,
    input  logic [2:0]             rx_bufstatus_i,
    output logic                   rx_realign_o,
    output logic                   fail_o,
    output logic [g_TS_W-1:0]      latency_last_o,
    output logic [g_TS_W-1:0]      latency_min_o,
    output logic [g_TS_W-1:0]      latency_max_o,
    output logic [g_CNT_W-1:0]     sample_cnt_o,
    output logic [g_CNT_W-1:0]     err_cnt_o
);

    localparam int W    = 8 * g_BYTES;
    localparam int IC_W = $clog2(g_IDLE_PERIOD);
    localparam int BL_W = (g_BLIND_PERIOD < 1) ? 1 : $clog2(g_BLIND_PERIOD + 1);
    localparam int GC_W = (g_NUM_SAMPLES < 2) ? 1 : $clog2(g_NUM_SAMPLES + 1);

    localparam logic [g_BYTES-1:0] K_MSB      = {1'b1, {(g_BYTES-1){1'b0}}};
    localparam logic [IC_W-1:0]    IDLE_LAST  = IC_W'(g_IDLE_PERIOD - 1);
    localparam logic [BL_W-1:0]    BLIND_LAST = BL_W'(g_BLIND_PERIOD);
    localparam logic [GC_W-1:0]    GOOD_LAST  = GC_W'(g_NUM_SAMPLES - 1);
    localparam logic [g_CNT_W-1:0] CNT_ONE    = g_CNT_W'(1);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_ALIGN = 3'd1,
        ST_BLIND = 3'd2,
        ST_HUNT  = 3'd3,
        ST_CHECK = 3'd4,
        ST_PASS  = 3'd5
    } state_t;

    state_t            state;
    logic [BL_W-1:0]   blind_cnt;
    logic [GC_W-1:0]   good_cnt;
    logic [g_TS_W-1:0] ts;
    logic [IC_W-1:0]   idle_cnt;
    logic [W-1:0]      ts_ext;

    logic              rx_pay;
    logic              rx_goodidle;
    logic              rx_bad;
    logic              buf_err;
    logic              in_check;
    logic              err_evt;
    logic              smp_evt;

    logic              smp_pend;
    logic [g_TS_W-1:0] lat_pend;

    // Only the over/underflow flag of the elastic buffer status matters.
    logic              unused_bufstatus;
    assign unused_bufstatus = ^rx_bufstatus_i[1:0];

    // ------------------------------------------------------------------
    // TX path: free-running timestamp, IDLE insertion
    // ------------------------------------------------------------------
    always_comb begin
        ts_ext               = '0;
        ts_ext[g_TS_W-1:0]   = ts;
    end

    // The TX word carries the timestamp of the cycle it was registered in,
    // so a direct wire loopback reads back a latency of exactly 1.
    always_ff @(posedge usrclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ts        <= '0;
            idle_cnt  <= '0;
            tx_data_o <= g_IDLE;
            tx_k_o    <= K_MSB;
        end else begin
            ts       <= ts + 1'b1;
            idle_cnt <= (idle_cnt == IDLE_LAST) ? '0 : idle_cnt + 1'b1;
            if (!valid_i || (idle_cnt == '0)) begin
                tx_data_o <= g_IDLE;
                tx_k_o    <= K_MSB;
            end else begin
                tx_data_o <= ts_ext;
                tx_k_o    <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX classification and per-cycle events
    // ------------------------------------------------------------------
    assign rx_pay      = (rx_k_i == '0);
    assign rx_goodidle = (rx_k_i == K_MSB) && (rx_data_i == g_IDLE);
    assign rx_bad      = !rx_pay && !rx_goodidle;
    assign buf_err     = rx_bufstatus_i[2];
    assign in_check    = (state == ST_CHECK) || (state == ST_PASS);

    // Loss of alignment counts as an error only once the checker is locked.
    assign err_evt = valid_i && in_check && (!rx_aligned_i || rx_bad || buf_err);
    assign smp_evt = valid_i && in_check && rx_aligned_i && !buf_err && rx_pay;

    // ------------------------------------------------------------------
    // Checker FSM; rx_realign_o and fail_o track the registered state
    // ------------------------------------------------------------------
    always_ff @(posedge usrclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_OFF;
            blind_cnt    <= '0;
            good_cnt     <= '0;
            rx_realign_o <= 1'b0;
            fail_o       <= 1'b1;
        end else begin
            rx_realign_o <= 1'b0;
            fail_o       <= 1'b1;
            if (!valid_i) begin
                state <= ST_OFF;
            end else begin
                case (state)
                    ST_OFF: begin
                        state        <= ST_ALIGN;
                        rx_realign_o <= 1'b1;
                    end
                    ST_ALIGN: begin
                        if (rx_aligned_i) begin
                            state     <= ST_BLIND;
                            blind_cnt <= '0;
                        end else begin
                            rx_realign_o <= 1'b1;
                        end
                    end
                    ST_BLIND: begin
                        if (!rx_aligned_i) begin
                            state        <= ST_ALIGN;
                            rx_realign_o <= 1'b1;
                        end else if (blind_cnt == BLIND_LAST) begin
                            state <= ST_HUNT;
                        end else begin
                            blind_cnt <= blind_cnt + 1'b1;
                        end
                    end
                    ST_HUNT: begin
                        good_cnt <= '0;
                        if (!rx_aligned_i) begin
                            state        <= ST_ALIGN;
                            rx_realign_o <= 1'b1;
                        end else if (rx_goodidle) begin
                            state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (err_evt) begin
                            state        <= rx_aligned_i ? ST_HUNT : ST_ALIGN;
                            rx_realign_o <= !rx_aligned_i;
                        end else if (smp_evt) begin
                            good_cnt <= good_cnt + 1'b1;
                            if (good_cnt == GOOD_LAST) begin
                                state  <= ST_PASS;
                                fail_o <= 1'b0;
                            end
                        end
                    end
                    ST_PASS: begin
                        if (err_evt) begin
                            state        <= rx_aligned_i ? ST_HUNT : ST_ALIGN;
                            rx_realign_o <= !rx_aligned_i;
                        end else begin
                            fail_o <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_OFF;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics. Samples pass through one pipeline stage before they
    // reach last/min/max; errors are counted in the cycle they occur.
    // A clear in the same cycle as an update is applied first.
    // ------------------------------------------------------------------
    always_ff @(posedge usrclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            smp_pend       <= 1'b0;
            lat_pend       <= '0;
            latency_last_o <= '0;
            latency_min_o  <= '1;
            latency_max_o  <= '0;
            sample_cnt_o   <= '0;
            err_cnt_o      <= '0;
        end else begin
            smp_pend <= smp_evt;
            lat_pend <= ts - rx_data_i[g_TS_W-1:0];

            if (clear_stats_i) begin
                latency_min_o <= '1;
                latency_max_o <= '0;
                sample_cnt_o  <= '0;
                err_cnt_o     <= '0;
            end

            if (smp_pend) begin
                latency_last_o <= lat_pend;
                if (clear_stats_i || (lat_pend < latency_min_o)) begin
                    latency_min_o <= lat_pend;
                end
                if (clear_stats_i || (lat_pend > latency_max_o)) begin
                    latency_max_o <= lat_pend;
                end
                if (clear_stats_i) begin
                    sample_cnt_o <= CNT_ONE;
                end else if (sample_cnt_o != '1) begin
                    sample_cnt_o <= sample_cnt_o + 1'b1;
                end
            end

            if (err_evt) begin
                if (clear_stats_i) begin
                    err_cnt_o <= CNT_ONE;
                end else if (err_cnt_o != '1) begin
                    err_cnt_o <= err_cnt_o + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
